// File: rtl/lock_display_ctrl_if.sv
// Keypad, comparator-event and display signals of the lock display controller.
// The master drives keys/events; the slave (controller) drives display and code.
interface lock_display_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_val;
    logic        key_clear;
    logic        evt_open;
    logic        evt_fail;
    logic        evt_close;
    logic [19:0] big_bin;
    logic [15:0] code_out;
    logic        code_ready;
    logic [2:0]  entry_count;

    modport master (
        output key_valid, key_val, key_clear, evt_open, evt_fail, evt_close,
        input  big_bin, code_out, code_ready, entry_count
    );

    modport slave (
        input  key_valid, key_val, key_clear, evt_open, evt_fail, evt_close,
        output big_bin, code_out, code_ready, entry_count
    );
endinterface

// File: rtl/lock_display_ctrl.sv
// Digital-lock front end: gathers four keypad digits, hands the code to the
// comparator and sequences the 4-digit display (CLSd / entry / OPEn / ----).
module lock_display_ctrl #(
    parameter int HOLD_CYCLES = 100000000,
    parameter int TIMER_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    lock_display_ctrl_if.slave bus
);
    localparam logic [19:0] CLSD_CODE = 20'b01100_11100_00101_01101;
    localparam logic [19:0] OPEN_CODE = 20'b00000_10000_01110_11110;
    localparam logic [19:0] DASH_CODE = 20'hFFFFF;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {ST_CLOSED, ST_ENTRY, ST_WAIT, ST_OPEN, ST_FAIL} state_t;

    state_t               state_reg,      state_next;
    logic [15:0]          buf_reg,        buf_next;
    logic [2:0]           count_reg,      count_next;
    logic [TIMER_W-1:0]   timer_reg,      timer_next;
    logic [15:0]          code_out_reg,   code_out_next;
    logic                 code_ready_reg, code_ready_next;
    logic [19:0]          big_bin_reg,    big_bin_next;

    logic                 key_ok;
    logic                 timeout;
    logic                 timer_clr;
    logic [15:0]          buf_shift;
    logic [19:0]          digit_disp;

    assign key_ok    = bus.key_valid && (bus.key_val <= 4'd9);
    assign timeout   = (timer_reg == TIMER_LAST);
    assign buf_shift = {buf_reg[11:0], bus.key_val};

    always_comb begin
        state_next      = state_reg;
        buf_next        = buf_reg;
        count_next      = count_reg;
        code_out_next   = code_out_reg;
        code_ready_next = 1'b0;
        timer_clr       = 1'b0;
        case (state_reg)
            ST_CLOSED: begin
                if (key_ok) begin
                    buf_next   = {12'h000, bus.key_val};
                    count_next = 3'd1;
                    timer_clr  = 1'b1;
                    state_next = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                // Clear wins over a simultaneous key; a key at the timeout edge restarts the timer.
                if (bus.key_clear) begin
                    buf_next   = 16'h0000;
                    count_next = 3'd0;
                    state_next = ST_CLOSED;
                end else if (key_ok) begin
                    buf_next   = buf_shift;
                    count_next = 3'(count_reg + 3'd1);
                    timer_clr  = 1'b1;
                    if (count_reg == 3'd3) begin
                        code_out_next   = buf_shift;
                        code_ready_next = 1'b1;
                        state_next      = ST_WAIT;
                    end
                end else if (timeout) begin
                    buf_next   = 16'h0000;
                    count_next = 3'd0;
                    state_next = ST_CLOSED;
                end
            end
            ST_WAIT: begin
                if (bus.evt_fail || timeout) begin
                    state_next = ST_FAIL;
                end else if (bus.evt_open) begin
                    state_next = ST_OPEN;
                end
                if (state_next != ST_WAIT) begin
                    buf_next   = 16'h0000;
                    count_next = 3'd0;
                end
            end
            ST_OPEN: begin
                if (bus.evt_close) begin
                    state_next = ST_CLOSED;
                end
            end
            ST_FAIL: begin
                if (timeout) begin
                    state_next = ST_CLOSED;
                end
            end
            default: begin
                state_next = ST_CLOSED;
                buf_next   = 16'h0000;
                count_next = 3'd0;
            end
        endcase
        timer_next = (timer_clr || (state_next != state_reg)) ? '0 : timer_reg + 1'b1;
    end

    // Right-aligned entry view: position gi shows a digit only once gi+1 digits are held.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign digit_disp[gi*5 +: 5] = (3'(gi) < count_next) ? {1'b0, buf_next[gi*4 +: 4]} : 5'h1F;
    end

    always_comb begin
        big_bin_next = CLSD_CODE;
        case (state_next)
            ST_ENTRY, ST_WAIT: big_bin_next = digit_disp;
            ST_OPEN:           big_bin_next = OPEN_CODE;
            ST_FAIL:           big_bin_next = DASH_CODE;
            default:           big_bin_next = CLSD_CODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_CLOSED;
            buf_reg        <= 16'h0000;
            count_reg      <= 3'd0;
            timer_reg      <= '0;
            code_out_reg   <= 16'h0000;
            code_ready_reg <= 1'b0;
            big_bin_reg    <= CLSD_CODE;
        end else begin
            state_reg      <= state_next;
            buf_reg        <= buf_next;
            count_reg      <= count_next;
            timer_reg      <= timer_next;
            code_out_reg   <= code_out_next;
            code_ready_reg <= code_ready_next;
            big_bin_reg    <= big_bin_next;
        end
    end

    assign bus.big_bin     = big_bin_reg;
    assign bus.code_out    = code_out_reg;
    assign bus.code_ready  = code_ready_reg;
    assign bus.entry_count = count_reg;
endmodule

// File: tb/tb_lock_display_ctrl.sv
// Scenario bench for lock_display_ctrl: expected codes are queued when the
// fourth key is driven and checked by a monitor when code_ready appears.
module tb_lock_display_ctrl;
    localparam int HOLD = 16;
    localparam logic [19:0] CLSD  = 20'b01100_11100_00101_01101;
    localparam logic [19:0] OPENC = 20'b00000_10000_01110_11110;
    localparam logic [19:0] DASH  = 20'hFFFFF;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [15:0] exp_q[$];

    lock_display_ctrl_if bus ();

    lock_display_ctrl #(.HOLD_CYCLES(HOLD), .TIMER_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard side: every code_ready must match the oldest queued code.
    always @(negedge clk) begin
        if (rst_n && bus.code_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL code_ready_unexpected: code_out=%h, none expected", bus.code_out);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.code_out !== e) begin
                    n_err++;
                    $display("FAIL code_out: got %h want %h", bus.code_out, e);
                end else begin
                    $display("code_ready: code_out=%h", bus.code_out);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_val   = k;
        tick();
        bus.key_valid = 1'b0;
        bus.key_val   = 4'd0;
        $display("key %0d -> big_bin=%b count=%0d", k, bus.big_bin, bus.entry_count);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_valid = 1'b0; bus.key_val = 4'd0; bus.key_clear = 1'b0;
        bus.evt_open = 1'b0; bus.evt_fail = 1'b0; bus.evt_close = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (bus.big_bin !== CLSD) begin n_err++; $display("FAIL reset_big_bin: got %b want %b", bus.big_bin, CLSD); end
        n_cmp++;
        if (bus.entry_count !== 3'd0 || bus.code_ready !== 1'b0 || bus.code_out !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got count=%0d ready=%b code=%h want 0/0/0", bus.entry_count, bus.code_ready, bus.code_out);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.big_bin !== CLSD) begin n_err++; $display("FAIL post_reset_big_bin: got %b want %b", bus.big_bin, CLSD); end
    endtask

    task automatic test_entry();
        logic [3:0]  keys[4];
        logic [19:0] exp_bb[4];
        keys   = '{4'd2, 4'd0, 4'd1, 4'd9};
        exp_bb = '{20'b11111_11111_11111_00010, 20'b11111_11111_00010_00000,
                   20'b11111_00010_00000_00001, 20'b00010_00000_00001_01001};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(16'h2019);
            press(keys[i]);
            n_cmp++;
            if (bus.big_bin !== exp_bb[i] || bus.entry_count !== 3'(i + 1)) begin
                n_err++;
                $display("FAIL entry_step%0d: got %b/%0d want %b/%0d", i, bus.big_bin, bus.entry_count, exp_bb[i], i + 1);
            end
            tick();
            n_cmp++;
            if (bus.big_bin !== exp_bb[i]) begin n_err++; $display("FAIL entry_idle%0d: got %b want %b", i, bus.big_bin, exp_bb[i]); end
        end
        n_cmp++;
        if (bus.code_out !== 16'h2019 || bus.code_ready !== 1'b0) begin
            n_err++;
            $display("FAIL entry_code_hold: got %h ready=%b want 2019 ready=0", bus.code_out, bus.code_ready);
        end
        bus.evt_open = 1'b1; tick(); bus.evt_open = 1'b0;
        bus.evt_close = 1'b1; tick(); bus.evt_close = 1'b0;
        n_cmp++;
        if (bus.big_bin !== CLSD || bus.code_out !== 16'h2019) begin
            n_err++;
            $display("FAIL entry_relock: got %b code=%h want %b code=2019", bus.big_bin, bus.code_out, CLSD);
        end
    endtask

    task automatic test_clear();
        press(4'd7);
        n_cmp++;
        if (bus.big_bin !== 20'b11111_11111_11111_00111) begin n_err++; $display("FAIL clear_one_digit: got %b", bus.big_bin); end
        bus.key_clear = 1'b1; bus.key_valid = 1'b1; bus.key_val = 4'd3;
        tick();
        bus.key_clear = 1'b0; bus.key_valid = 1'b0; bus.key_val = 4'd0;
        n_cmp++;
        if (bus.big_bin !== CLSD || bus.entry_count !== 3'd0) begin
            n_err++;
            $display("FAIL clear_priority: got %b/%0d want %b/0", bus.big_bin, bus.entry_count, CLSD);
        end
        repeat (3) tick();
    endtask

    task automatic test_open();
        exp_q.push_back(16'h1234);
        for (int i = 1; i <= 4; i++) press(4'(i));
        n_cmp++;
        if (bus.big_bin !== 20'b00001_00010_00011_00100 || bus.entry_count !== 3'd4) begin
            n_err++;
            $display("FAIL open_wait_disp: got %b/%0d want 1234/4", bus.big_bin, bus.entry_count);
        end
        bus.key_clear = 1'b1; tick(); bus.key_clear = 1'b0;
        n_cmp++;
        if (bus.entry_count !== 3'd4) begin n_err++; $display("FAIL wait_clear_ignored: got count %0d want 4", bus.entry_count); end
        bus.evt_open = 1'b1; tick(); bus.evt_open = 1'b0;
        n_cmp++;
        if (bus.big_bin !== OPENC || bus.entry_count !== 3'd0) begin
            n_err++;
            $display("FAIL open_disp: got %b/%0d want %b/0", bus.big_bin, bus.entry_count, OPENC);
        end
        press(4'd5);
        bus.evt_fail = 1'b1; tick(); bus.evt_fail = 1'b0;
        repeat (HOLD + 4) tick();
        n_cmp++;
        if (bus.big_bin !== OPENC) begin n_err++; $display("FAIL open_ignores: got %b want %b", bus.big_bin, OPENC); end
        bus.evt_close = 1'b1; tick(); bus.evt_close = 1'b0;
        n_cmp++;
        if (bus.big_bin !== CLSD) begin n_err++; $display("FAIL open_close: got %b want %b", bus.big_bin, CLSD); end
    endtask

    task automatic test_fail_dwell();
        int bad;
        exp_q.push_back(16'h5555);
        for (int i = 0; i < 4; i++) press(4'd5);
        bus.evt_open = 1'b1; bus.evt_fail = 1'b1;
        tick();
        bus.evt_open = 1'b0; bus.evt_fail = 1'b0;
        bad = 0;
        for (int i = 0; i < HOLD; i++) begin
            if (bus.big_bin !== DASH) bad++;
            if (i < HOLD - 1) tick();
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL fail_dwell: %0d of %0d cycles not dashes", bad, HOLD); end
        tick();
        n_cmp++;
        if (bus.big_bin !== CLSD) begin n_err++; $display("FAIL fail_exit: got %b want %b", bus.big_bin, CLSD); end
    endtask

    task automatic test_wait_timeout();
        exp_q.push_back(16'h8888);
        for (int i = 0; i < 4; i++) press(4'd8);
        repeat (HOLD - 1) tick();
        n_cmp++;
        if (bus.big_bin !== 20'b01000_01000_01000_01000) begin n_err++; $display("FAIL wait_before_timeout: got %b", bus.big_bin); end
        tick();
        n_cmp++;
        if (bus.big_bin !== DASH) begin n_err++; $display("FAIL wait_timeout: got %b want %b", bus.big_bin, DASH); end
        repeat (HOLD) tick();
        n_cmp++;
        if (bus.big_bin !== CLSD) begin n_err++; $display("FAIL wait_fail_exit: got %b want %b", bus.big_bin, CLSD); end
    endtask

    task automatic test_entry_timeout();
        press(4'd4);
        repeat (HOLD - 1) tick();
        n_cmp++;
        if (bus.big_bin !== 20'b11111_11111_11111_00100) begin n_err++; $display("FAIL entry_before_timeout: got %b", bus.big_bin); end
        tick();
        n_cmp++;
        if (bus.big_bin !== CLSD || bus.entry_count !== 3'd0) begin
            n_err++;
            $display("FAIL entry_timeout: got %b/%0d want %b/0", bus.big_bin, bus.entry_count, CLSD);
        end
        for (int k = 10; k < 16; k++) begin
            press(4'(k));
            n_cmp++;
            if (bus.big_bin !== CLSD || bus.entry_count !== 3'd0) begin
                n_err++;
                $display("FAIL invalid_key%0d: got %b/%0d want %b/0", k, bus.big_bin, bus.entry_count, CLSD);
            end
        end
    endtask

    task automatic test_async_reset();
        press(4'd1); press(4'd2); press(4'd3);
        n_cmp++;
        if (bus.entry_count !== 3'd3) begin n_err++; $display("FAIL arst_pre_count: got %0d want 3", bus.entry_count); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.big_bin !== CLSD || bus.entry_count !== 3'd0 || bus.code_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arst_entry: got %b/%0d/%b want %b/0/0", bus.big_bin, bus.entry_count, bus.code_ready, CLSD);
        end
        tick();
        rst_n = 1'b1;
        tick();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        n_cmp++;
        if (bus.code_ready !== 1'b1 || bus.code_out !== 16'h1234) begin
            n_err++;
            $display("FAIL arst_ready_pre: got %b/%h want 1/1234", bus.code_ready, bus.code_out);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.code_ready !== 1'b0 || bus.code_out !== 16'h0 || bus.big_bin !== CLSD) begin
            n_err++;
            $display("FAIL arst_ready_drop: got %b/%h/%b want 0/0000/%b", bus.code_ready, bus.code_out, bus.big_bin, CLSD);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_entry();
        test_clear();
        test_open();
        test_fail_dwell();
        test_wait_timeout();
        test_entry_timeout();
        test_async_reset();
        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d codes never seen, want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
